// File: rtl/demux_pkg.sv
// demux_pkg: shared types and sizes for the registered 1-to-3 demultiplexer.
package demux_pkg;
  typedef enum logic [1:0] {
    DEST_A    = 2'b00,
    DEST_B    = 2'b01,
    DEST_C    = 2'b10,
    DEST_DROP = 2'b11
  } dest_e;
  typedef enum logic {S_EMPTY, S_HOLD} skid_e;
  localparam int N_CH       = 3;
  localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry output register that drains on handshake and can reload in the same cycle.
module demux_out_slot #(
  parameter int DAT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 ready,
  input  logic [DAT_WIDTH-1:0] din,
  output logic                 valid,
  output logic [DAT_WIDTH-1:0] dout
);
  logic                 valid_d, valid_q;
  logic [DAT_WIDTH-1:0] data_d, data_q;
  always_comb begin
    valid_d = load | (valid_q & ~ready);
    data_d  = load ? din : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign dout  = data_q;
endmodule

// File: rtl/demux_3_1_reg.sv
// demux_3_1_reg: routes a tagged stream to three registered channels through a one-entry skid; sel=11 words are dropped and counted.
module demux_3_1_reg
  import demux_pkg::*;
#(
  parameter int DAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [DAT_WIDTH-1:0]  in_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [DAT_WIDTH-1:0]  out_data_a,
  output logic [DAT_WIDTH-1:0]  out_data_b,
  output logic [DAT_WIDTH-1:0]  out_data_c,
  output logic                  drop_o,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  skid_e                 state_d, state_q;
  logic [1:0]            skid_sel_d, skid_sel_q;
  logic [DAT_WIDTH-1:0]  skid_data_d, skid_data_q;
  logic                  drop_d, drop_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d, drop_cnt_q;
  logic [3:0]            free;
  logic                  hold, accept, is_drop, go, capture;
  logic [1:0]            tgt;
  logic [N_CH-1:0]       load;
  logic [DAT_WIDTH-1:0]  load_data;
  logic [DAT_WIDTH-1:0]  slot_data [N_CH];
  // free[3] pads the drop code so a 2-bit select always indexes a real bit
  always_comb begin
    free        = {1'b0, ~out_valid | out_ready};
    hold        = state_q == S_HOLD;
    accept      = in_valid && !hold;
    is_drop     = in_sel == DEST_DROP;
    tgt         = hold ? skid_sel_q : in_sel;
    go          = hold ? free[skid_sel_q] : accept && !is_drop && free[in_sel];
    capture     = accept && !is_drop && !free[in_sel];
    load        = {go && tgt == 2'd2, go && tgt == 2'd1, go && tgt == 2'd0};
    load_data   = hold ? skid_data_q : in_data;
    state_d     = hold ? (go ? S_EMPTY : S_HOLD) : (capture ? S_HOLD : S_EMPTY);
    skid_sel_d  = capture ? in_sel : skid_sel_q;
    skid_data_d = capture ? in_data : skid_data_q;
    drop_d      = accept && is_drop;
    drop_cnt_d  = (drop_d && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      skid_sel_q  <= '0;
      skid_data_q <= '0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      skid_sel_q  <= skid_sel_d;
      skid_data_q <= skid_data_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_out_slot #(.DAT_WIDTH(DAT_WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .ready(out_ready[k]),
      .din  (load_data),
      .valid(out_valid[k]),
      .dout (slot_data[k])
    );
  end
  assign in_ready   = state_q == S_EMPTY;
  assign out_data_a = slot_data[0];
  assign out_data_b = slot_data[1];
  assign out_data_c = slot_data[2];
  assign drop_o     = drop_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_demux_3_1_reg.sv
// tb_demux_3_1_reg: directed and random stimulus against a per-channel behavioural model of the demux.
module tb_demux_3_1_reg;
  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] out_data_a, out_data_b, out_data_c;
  logic        drop_o;
  logic [7:0]  drop_cnt;
  int checks = 0;
  int errors = 0;

  demux_3_1_reg #(.DAT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data_a(out_data_a), .out_data_b(out_data_b),
    .out_data_c(out_data_c), .drop_o(drop_o), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Model: what each consumer is currently being offered, plus at most one parked word.
  logic [2:0]  m_v     = '0;
  logic [31:0] m_d [3] = '{0, 0, 0};
  logic        m_park  = 0;
  int          m_psel  = 0;
  logic [31:0] m_pdata = 0;
  logic        m_drop  = 0;
  int          m_cnt   = 0;
  logic [2:0]  m_fr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_v = '0; m_park = 0; m_drop = 0; m_cnt = 0;
      for (int k = 0; k < 3; k++) m_d[k] = 0;
    end else begin
      m_fr   = ~m_v | out_ready;
      m_drop = 0;
      m_v    = m_v & ~out_ready;
      if (m_park) begin
        if (m_fr[m_psel]) begin
          m_v[m_psel] = 1; m_d[m_psel] = m_pdata; m_park = 0;
        end
      end else if (in_valid) begin
        if (in_sel == 2'd3) begin
          m_drop = 1;
          m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else if (m_fr[in_sel]) begin
          m_v[in_sel] = 1; m_d[in_sel] = in_data;
        end else begin
          m_park = 1; m_psel = int'(in_sel); m_pdata = in_data;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, !m_park});
    chk("out_valid", {29'b0, out_valid}, {29'b0, m_v});
    chk("drop_o", {31'b0, drop_o}, {31'b0, m_drop});
    chk("drop_cnt", {24'b0, drop_cnt}, m_cnt);
    if (m_v[0]) chk("data_a", out_data_a, m_d[0]);
    if (m_v[1]) chk("data_b", out_data_b, m_d[1]);
    if (m_v[2]) chk("data_c", out_data_c, m_d[2]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] d);
    in_valid = 1; in_sel = s; in_data = d;
    cyc();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 3'b111;
    cyc(); cyc();
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {29'b0, out_valid}, 0);
    chk("rst_drop_cnt", {24'b0, drop_cnt}, 0);
    chk("rst_data_c", out_data_c, 0);
    rst = 0;
    cyc();
    // basic routing
    send(2'd0, 32'h11);
    chk("route_a_v", {29'b0, out_valid}, 3'b001);
    chk("route_a_d", out_data_a, 32'h11);
    send(2'd1, 32'h22);
    chk("route_b_v", {29'b0, out_valid}, 3'b010);
    chk("route_b_d", out_data_b, 32'h22);
    send(2'd2, 32'h33);
    chk("route_c_v", {29'b0, out_valid}, 3'b100);
    chk("route_c_d", out_data_c, 32'h33);
    chk("route_in_ready", {31'b0, in_ready}, 1);
    in_valid = 0; cyc();
    // skid path
    out_ready = 3'b110;
    send(2'd0, 32'hA1);
    send(2'd0, 32'hA2);
    chk("skid_in_ready", {31'b0, in_ready}, 0);
    chk("skid_hold_d", out_data_a, 32'hA1);
    in_valid = 0; cyc();
    chk("skid_still_d", out_data_a, 32'hA1);
    out_ready = 3'b111; cyc();
    chk("skid_second_d", out_data_a, 32'hA2);
    chk("skid_second_v", {29'b0, out_valid}, 3'b001);
    chk("skid_release", {31'b0, in_ready}, 1);
    cyc();
    chk("skid_empty", {29'b0, out_valid}, 0);
    // channel independence with b stalled
    out_ready = 3'b101;
    send(2'd1, 32'hB1);
    send(2'd0, 32'hA5);
    chk("indep_a_v", {29'b0, out_valid}, 3'b011);
    chk("indep_a_d", out_data_a, 32'hA5);
    send(2'd2, 32'hC5);
    chk("indep_c_v", {29'b0, out_valid}, 3'b110);
    chk("indep_c_d", out_data_c, 32'hC5);
    chk("indep_b_d", out_data_b, 32'hB1);
    in_valid = 0; out_ready = 3'b111; cyc(); cyc();
    // drop path with saturation
    for (int i = 0; i < 300; i++) begin
      send(2'd3, $urandom);
      chk("drop_pulse", {31'b0, drop_o}, 1);
      chk("drop_no_out", {29'b0, out_valid}, 0);
      chk("drop_in_ready", {31'b0, in_ready}, 1);
    end
    in_valid = 0;
    chk("drop_sat", {24'b0, drop_cnt}, 255);
    cyc();
    chk("drop_end", {31'b0, drop_o}, 0);
    // reset with slots and skid loaded
    out_ready = 3'b000;
    send(2'd0, 32'hD1);
    send(2'd1, 32'hD2);
    send(2'd0, 32'hD3);
    in_valid = 0;
    chk("pre_rst_hold", {31'b0, in_ready}, 0);
    rst = 1; #1;
    chk("mid_rst_v", {29'b0, out_valid}, 0);
    chk("mid_rst_rdy", {31'b0, in_ready}, 1);
    chk("mid_rst_cnt", {24'b0, drop_cnt}, 0);
    chk("mid_rst_da", out_data_a, 0);
    cyc(); rst = 0; out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_v", {29'b0, out_valid}, 0);
    end
    // back-to-back on channel c
    for (int i = 0; i < 16; i++) begin
      send(2'd2, i);
      chk("b2b_v", {31'b0, out_valid[2]}, 1);
      chk("b2b_d", out_data_c, i);
    end
    in_valid = 0; cyc();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 3'($urandom);
      if ($urandom_range(0, 499) == 0) rst = 1;
      cyc();
      rst = 0;
    end
    in_valid = 0; out_ready = 3'b111;
    cyc(); cyc();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
